// File: rtl/keccak_slice_pkg.sv
// keccak_slice_pkg: shared tables and helpers for the slice-serial Keccak
// pre-theta datapath.
//   pi_src(t)       : lane whose bit lands in output lane t after pi
//   bit_sel(t, sw)  : rho offset of that source lane, mod slice width
//   cap_sub(t, sw)  : sub-round in which that bit sits in the RAM write word
//   chi(g)          : chi over a 25-bit slice
// Slice vectors place lane L at bit (24-L), so lane 0 is the MSB.
package keccak_slice_pkg;

  // Rho rotation offsets indexed by lane L = x + 5*y.
  localparam int unsigned RHO [25] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  // Output lane t = x' + 5*y' with x' = y and y' = (2x + 3y) mod 5.
  // Solving for the source: y = x', x = 3*(y' - 3x') mod 5.
  function automatic int unsigned pi_src(input int unsigned t);
    int unsigned xo, yo, xs;
    xo = t % 5;
    yo = t / 5;
    xs = (3 * ((yo + 15 - 3 * xo) % 5)) % 5;
    return xs + 5 * xo;
  endfunction

  function automatic int unsigned bit_sel(input int unsigned t, input int unsigned sw);
    return RHO[pi_src(t)] % sw;
  endfunction

  function automatic int unsigned cap_sub(input int unsigned t, input int unsigned sw);
    return RHO[pi_src(t)] / sw;
  endfunction

  function automatic logic [24:0] chi(input logic [24:0] g);
    logic [24:0] o;
    o = '0;
    for (int unsigned r = 0; r < 25; r += 5) begin
      for (int unsigned x = 0; x < 5; x++) begin
        o[24 - (r + x)] = g[24 - (r + x)] ^
                          (~g[24 - (r + (x + 1) % 5)] & g[24 - (r + (x + 2) % 5)]);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/slice_chi_iota.sv
// slice_chi_iota: chi over one 25-bit slice, then iota on lane 0.
//   g      : gathered (pi-permuted) slice, lane 0 at the MSB
//   rc_bit : round-constant bit for this slice
//   out    : chi/iota result, same bit order as g
module slice_chi_iota
  import keccak_slice_pkg::*;
(
  input  logic [24:0] g,
  input  logic        rc_bit,
  output logic [24:0] out
);

  always_comb begin
    out     = chi(g);
    out[24] = out[24] ^ rc_bit;
  end

endmodule

// File: rtl/pre_theta_pipe.sv
// pre_theta_pipe: sequences sub-rounds/rounds of a slice-serial Keccak
// permutation and presents the slice feeding theta.
//   clk, rst (async, active-high), pre_en (block enable)
//   start, step, absorb, rc_bit           : control inputs
//   k_ram_o_all, k_ram_i_all, ci_out      : 25*SLICE_W words, lane L bit b at L*SLICE_W+b
//   pre_theta, pre_valid                  : slice to theta and its valid
//   busy, done, sub_cnt, rnd_cnt          : sequencing status
// Optional macro PRE_THETA_OUT_REG_EN adds an output register on pre_theta
// (pre_valid latency becomes 2).
module pre_theta_pipe
  import keccak_slice_pkg::*;
#(
  parameter  int SLICE_W = 8,
  parameter  int NUM_RND = 24,
  localparam int SUBS    = 64 / SLICE_W,
  localparam int SUB_W   = $clog2(SUBS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pre_en,
  input  logic                   start,
  input  logic                   step,
  input  logic                   absorb,
  input  logic                   rc_bit,
  input  logic [25*SLICE_W-1:0]  k_ram_o_all,
  input  logic [25*SLICE_W-1:0]  k_ram_i_all,
  input  logic [25*SLICE_W-1:0]  ci_out,
  output logic [24:0]            pre_theta,
  output logic                   pre_valid,
  output logic                   busy,
  output logic                   done,
  output logic [SUB_W-1:0]       sub_cnt,
  output logic [4:0]             rnd_cnt
);

  logic [24:0] slice_q, gather_q;
  logic [24:0] slice_d, gather_d;
  logic [24:0] chi_out, mux_out;
  logic        valid_q;
  logic        acc_start, acc_step;
  logic        last_sub, last_step;

  assign acc_start = pre_en & ~busy & start;
  assign acc_step  = pre_en & busy & step;
  assign last_sub  = (sub_cnt == SUB_W'(SUBS - 1));
  assign last_step = last_sub && (rnd_cnt == 5'(NUM_RND - 1));

  always_comb begin
    slice_d  = '0;
    gather_d = gather_q;
    for (int unsigned l = 0; l < 25; l++) begin
      slice_d[24 - l] = (absorb || rnd_cnt == 5'd0) ? k_ram_o_all[l * SLICE_W]
                                                    : ci_out[l * SLICE_W];
    end
    for (int unsigned t = 0; t < 25; t++) begin
      if (sub_cnt == SUB_W'(cap_sub(t, SLICE_W)))
        gather_d[24 - t] = k_ram_i_all[pi_src(t) * SLICE_W + bit_sel(t, SLICE_W)];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_q  <= '0;
      gather_q <= '0;
      valid_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sub_cnt  <= '0;
      rnd_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (!pre_en) begin
        slice_q  <= '0;
        gather_q <= '0;
        valid_q  <= 1'b0;
      end else begin
        valid_q <= acc_step;
        if (acc_step) begin
          slice_q  <= slice_d;
          gather_q <= gather_d;
          if (last_step) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            sub_cnt <= '0;
            rnd_cnt <= '0;
          end else if (last_sub) begin
            sub_cnt <= '0;
            rnd_cnt <= rnd_cnt + 5'd1;
          end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
          end
        end else if (acc_start) begin
          busy    <= 1'b1;
          sub_cnt <= '0;
          rnd_cnt <= '0;
        end
      end
    end
  end

  slice_chi_iota u_chi (
    .g      (gather_q),
    .rc_bit (rc_bit),
    .out    (chi_out)
  );

  assign mux_out = (last_sub && rnd_cnt != 5'd0 && !absorb) ? chi_out : slice_q;

`ifdef PRE_THETA_OUT_REG_EN
  logic [24:0] out_q;
  logic        valid2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      valid2_q <= 1'b0;
    end else if (!pre_en) begin
      out_q    <= '0;
      valid2_q <= 1'b0;
    end else begin
      out_q    <= mux_out;
      valid2_q <= valid_q;
    end
  end

  assign pre_theta = out_q;
  assign pre_valid = valid2_q;
`else
  assign pre_theta = mux_out;
  assign pre_valid = valid_q;
`endif

endmodule

// File: tb/tb_pre_theta_pipe.sv
module tb_pre_theta_pipe;

  localparam int SW = 8;
  localparam int W  = 25 * SW;

  logic          clk = 1'b0;
  logic          rst, pre_en, start, step, absorb, rc_bit;
  logic [W-1:0]  k_ram_o_all, k_ram_i_all, ci_out;
  logic [24:0]   pre_theta;
  logic          pre_valid, busy, done;
  logic [2:0]    sub_cnt;
  logic [4:0]    rnd_cnt;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [24:0] expq[$];

  always #5 clk = ~clk;

  pre_theta_pipe #(.SLICE_W(SW), .NUM_RND(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .pre_en      (pre_en),
    .start       (start),
    .step        (step),
    .absorb      (absorb),
    .rc_bit      (rc_bit),
    .k_ram_o_all (k_ram_o_all),
    .k_ram_i_all (k_ram_i_all),
    .ci_out      (ci_out),
    .pre_theta   (pre_theta),
    .pre_valid   (pre_valid),
    .busy        (busy),
    .done        (done),
    .sub_cnt     (sub_cnt),
    .rnd_cnt     (rnd_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word whose lane-L bit 0 is tgt[24-L]; all other bits are fill.
  function automatic logic [W-1:0] mk(input logic [24:0] tgt, input logic fill);
    logic [W-1:0] w;
    w = fill ? '1 : '0;
    for (int l = 0; l < 25; l++) w[l*SW] = tgt[24-l];
    return w;
  endfunction

  // Issue one step from a falling edge; returns at the following falling edge.
  task automatic do_step(input logic [24:0] exp);
    expq.push_back(exp);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid slice.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (pre_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 32'(pre_theta), 32'h0);
          chk("unexpected_valid_flag", 32'(pre_valid), 32'h0);
        end else begin
          chk("pre_theta", 32'(pre_theta), 32'(expq.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pre_en = 1'b0; start = 1'b0; step = 1'b0;
    absorb = 1'b0; rc_bit = 1'b0;
    k_ram_o_all = '0; k_ram_i_all = '0; ci_out = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_valid", 32'(pre_valid), 32'h0);
    chk("rst_theta", 32'(pre_theta), 32'h0);
    chk("rst_sub", 32'(sub_cnt), 32'h0);
    chk("rst_rnd", 32'(rnd_cnt), 32'h0);

    @(negedge clk);
    rst = 1'b0; pre_en = 1'b1;
    k_ram_o_all = mk(25'h1555555, 1'b1);
    ci_out      = mk(25'h0000000, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_sub", 32'(sub_cnt), 32'h0);
    chk("start_rnd", 32'(rnd_cnt), 32'h0);

    // Round 0: slice taken from the RAM read word.
    for (int i = 0; i < 8; i++) do_step(25'h1555555);
    chk("r0_rnd", 32'(rnd_cnt), 32'h1);
    chk("r0_sub", 32'(sub_cnt), 32'h0);

    // Round 1: slice from chi/iota word; gather all zero so last sub-round
    // shows only the round-constant bit on lane 0.
    k_ram_o_all = mk(25'h0000000, 1'b1);
    ci_out      = mk(25'h0ABCDEF, 1'b1);
    rc_bit      = 1'b1;
    for (int i = 1; i <= 8; i++) do_step(i == 7 ? 25'h1000000 : 25'h0ABCDEF);

    // Round 2: lane 6 all ones lands in gather bit 1 (row 0, x=1);
    // chi of that row sets lanes 1 and 4.
    ci_out      = mk(25'h1234567, 1'b1);
    rc_bit      = 1'b0;
    k_ram_i_all = '0;
    k_ram_i_all[55:48] = 8'hFF;
    for (int i = 1; i <= 8; i++) do_step(i == 7 ? 25'h0900000 : 25'h1234567);

    // Round 3: two steps, then disable with start held.
    ci_out      = mk(25'h0F0F0F0, 1'b1);
    k_ram_i_all = '0;
    for (int i = 0; i < 2; i++) do_step(25'h0F0F0F0);
    repeat (3) @(negedge clk);
    pre_en = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    chk("dis_sub", 32'(sub_cnt), 32'h2);
    chk("dis_rnd", 32'(rnd_cnt), 32'h3);
    chk("dis_busy", 32'(busy), 32'h1);
    chk("dis_valid", 32'(pre_valid), 32'h0);
    chk("dis_theta", 32'(pre_theta), 32'h0);
    pre_en = 1'b1;
    do_step(25'h0F0F0F0);
    start = 1'b0;
    chk("step_start_sub", 32'(sub_cnt), 32'h3);
    chk("step_start_rnd", 32'(rnd_cnt), 32'h3);

    // Remaining 165 steps in absorb mode up to the end of round 23.
    absorb = 1'b1;
    k_ram_o_all = mk(25'h0AAAAAA, 1'b0);
    for (int i = 0; i < 164; i++) do_step(25'h0AAAAAA);
    chk("pre_end_busy", 32'(busy), 32'h1);
    chk("pre_end_rnd", 32'(rnd_cnt), 32'd23);
    chk("pre_end_sub", 32'(sub_cnt), 32'h7);
    do_step(25'h0AAAAAA);
    chk("end_done", 32'(done), 32'h1);
    chk("end_busy", 32'(busy), 32'h0);
    chk("end_rnd", 32'(rnd_cnt), 32'h0);
    @(negedge clk);
    chk("done_pulse_len", 32'(done), 32'h0);
    repeat (4) @(negedge clk);
    chk("drain1", 32'(expq.size()), 32'h0);

    // Second run aborted by reset in round 3.
    k_ram_o_all = mk(25'h1C3C3C3, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 25; i++) do_step(25'h1C3C3C3);
    chk("abort_rnd", 32'(rnd_cnt), 32'h3);
    chk("abort_sub", 32'(sub_cnt), 32'h1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_theta", 32'(pre_theta), 32'h0);
    chk("abort_valid", 32'(pre_valid), 32'h0);
    chk("abort_counts", 32'({sub_cnt, rnd_cnt}), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("no_restart_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("no_restart_valid", 32'(pre_valid), 32'h0);
    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt), 32'h1);
    chk("drain2", 32'(expq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pre_theta_pipe.md
PRE_THETA_PIPE -- requirements
Module: pre_theta_pipe

Interface
REQ-001 SHALL have parameter SLICE_W, default 8: bits per lane held in one RAM word; legal values 4, 8, 16.
REQ-002 SHALL have parameter NUM_RND, default 24: Keccak rounds per permutation.
REQ-003 SHALL derive localparam SUBS = 64/SLICE_W, the number of sub-rounds per round.
REQ-004 SHALL have port clk, input, 1: single clock; all flops use the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port pre_en, input, 1: block enable.
REQ-007 SHALL have port start, input, 1: begin permutation.
REQ-008 SHALL have port step, input, 1: advance one sub-round.
REQ-009 SHALL have port absorb, input, 1: raw-load mode.
REQ-010 SHALL have port rc_bit, input, 1: iota round-constant bit for the wrap slice.
REQ-011 SHALL have port k_ram_o_all, input, 25*SLICE_W: RAM read word; lane L bit b is at index L*SLICE_W+b.
REQ-012 SHALL have port k_ram_i_all, input, 25*SLICE_W: RAM write word, rho-applied.
REQ-013 SHALL have port ci_out, input, 25*SLICE_W: chi/iota word, same bit layout as k_ram_o_all.
REQ-014 SHALL have port pre_theta, output, 25: slice presented to theta.
REQ-015 SHALL have port pre_valid, output, 1: pre_theta is valid.
REQ-016 SHALL have port busy, output, 1: permutation in progress.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at permutation end.
REQ-018 SHALL have port sub_cnt, output, $clog2(SUBS): current sub-round.
REQ-019 SHALL have port rnd_cnt, output, 5: current round.

Function
REQ-020 SHALL accept start only when busy=0 and pre_en=1, setting sub_cnt=0, rnd_cnt=0, busy=1 on the next edge; start while busy SHALL be ignored.
REQ-021 SHALL accept a step only when busy=1 and pre_en=1.
REQ-022 On an accepted step, sub_cnt SHALL increment; at SUBS-1 it SHALL wrap to 0 and rnd_cnt SHALL increment.
REQ-023 An accepted step at rnd_cnt=NUM_RND-1 and sub_cnt=SUBS-1 SHALL clear busy, zero both counters and pulse done for one cycle.
REQ-024 Slice register SHALL capture bit 0 of each lane (index L*SLICE_W) on an accepted step: from k_ram_o_all if absorb=1 or rnd_cnt=0, else from ci_out.
REQ-025 Gather register bit t SHALL capture k_ram_i_all[PI_SRC[t]*SLICE_W+BIT_SEL[t]] on an accepted step when sub_cnt=CAP_SUB[t]; all other gather bits SHALL hold.
REQ-026 Combinational output SHALL be chi(gather) when sub_cnt=SUBS-1, rnd_cnt!=0 and absorb=0, else the slice register.
REQ-027 chi SHALL be, per row base r: out[r+x] = g[r+x] ^ (~g[r+(x+1)%5] & g[r+(x+2)%5]).
REQ-028 Lane 0 of the chi output SHALL additionally be XORed with rc_bit.
REQ-029 pre_valid SHALL assert exactly 1 cycle after each accepted step (latency 1).
REQ-030 When pre_en=0, slice and gather registers and pre_valid SHALL clear on the next edge; counters and busy SHALL hold.
REQ-031 When step and start coincide while busy, only step SHALL take effect.

Reset
REQ-032 rst=1 SHALL asynchronously force all registers and outputs to 0: pre_theta, pre_valid, busy, done, sub_cnt, rnd_cnt, slice, gather.
REQ-033 Reset asserted mid-permutation SHALL abort it; a new start is required afterwards.

Configuration
REQ-034 SHALL compile in, when PRE_THETA_OUT_REG_EN is defined, an output register on pre_theta; pre_valid latency is then 2 cycles and pre_en=0 clears that register.
REQ-035 Without PRE_THETA_OUT_REG_EN, pre_theta SHALL be the combinational mux of REQ-026.

Structure
REQ-036 Package keccak_slice_pkg SHALL hold the tables PI_SRC[25], BIT_SEL[25] (rho offset mod SLICE_W) and CAP_SUB[25], each as a function of SLICE_W, plus the chi function.
REQ-037 The chi/iota slice logic SHALL be the sub-module slice_chi_iota (25-bit in, rc_bit, 25-bit out).

Verification
REQ-038 Reset mid-run: rst pulse at rnd_cnt=3 -> busy=0, all outputs 0 on the same cycle.
REQ-039 SLICE_W=8, start then 8 steps with rnd_cnt=0 and k_ram_o_all lane bits 0 = 25'h1555555 -> pre_theta=25'h1555555 each cycle, and rnd_cnt=1 after the 8th step.
REQ-040 rnd_cnt=1, gather preloaded to all zeros, rc_bit=1 at sub_cnt=7 -> pre_theta=25'h1000000 (lane 0 only, given index 0 is the MSB).
REQ-041 Full run with NUM_RND=24, SLICE_W=8: 192 steps -> done pulses exactly once and busy falls on the same edge.
REQ-042 start while busy and pre_en=0 for 3 cycles -> counters unchanged, pre_valid=0, slice and gather cleared.
REQ-043 With PRE_THETA_OUT_REG_EN defined -> the same vectors as REQ-039, delayed by one cycle.
